// File: rtl/sub4_serial_seq.sv
// sub4_serial_seq: wide a - b - borrow_in computed one 4-bit nibble per clock, LSB first
module sub4_serial_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   borrow_in,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   diff,
   output logic                   borrow_out,
   output logic                   zero
);
   localparam int W = 4*NIBBLES;
   localparam logic [3:0] LAST = 4'(NIBBLES-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   logic [3:0]     idx;
   logic           brw;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [4:0]     sub;
   logic [W-1:0]   diff_nx;

   // one borrow-chain nibble slice and the result with the current nibble merged in
   always_comb begin
      sub = {1'b0, a_r[4*idx +: 4]} - {1'b0, b_r[4*idx +: 4]} - {4'd0, brw};
      diff_nx = diff;
      diff_nx[4*idx +: 4] = sub[3:0];
   end

   // sequencer: latch operands on start, walk the nibbles, pulse done, return to idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         brw        <= 1'b0;
         a_r        <= '0;
         b_r        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         zero       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a_r   <= a;
               b_r   <= b;
               brw   <= borrow_in;
               idx   <= '0;
               busy  <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               diff <= diff_nx;
               brw  <= sub[4];
               if (idx == LAST) begin
                  borrow_out <= sub[4];
                  zero       <= (diff_nx == '0);
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sub4_serial_seq.sv
// tb_sub4_serial_seq: randomized and directed checks of the serial subtractor against an arithmetic model
module tb_sub4_serial_seq;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          borrow_in = 1'b0;
   logic          busy;
   logic          done;
   logic [W-1:0]  diff;
   logic          borrow_out;
   logic          zero;

   int checks = 0;
   int errors = 0;

   sub4_serial_seq #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs one operation from a negedge; ends at the negedge after the return to idle.
   // With noise set, operands churn every cycle and start is re-pulsed in RUN and DONE.
   task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bin, input bit noise);
      int exp_full;
      logic [W-1:0] exp_diff;
      logic exp_bo;
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at = -1;
      exp_full = int'(av) - int'(bv) - int'(bin);
      exp_diff = W'(exp_full + (1 << W));
      exp_bo   = (int'(av) < int'(bv) + int'(bin));
      a = av; b = bv; borrow_in = bin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_at = k;
         end
         if (noise) begin
            a = W'($urandom);
            b = W'($urandom);
            borrow_in = 1'($urandom);
            start = (k == 1 || k == 4);
         end
      end
      start = 1'b0;
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_done_at"}, done_at, 4);
      chk({tag, "_busy_cnt"}, busy_cnt, 5);
      chk({tag, "_diff"}, diff, exp_diff);
      chk({tag, "_bo"}, borrow_out, exp_bo);
      chk({tag, "_zero"}, zero, exp_diff == '0);
   endtask

   initial begin
      int extra;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      rst = 1'b0;
      @(negedge clk);
      do_op("basic", 16'h1234, 16'h0234, 1'b0, 1'b0);
      do_op("under", 16'h0003, 16'h0008, 1'b1, 1'b0);
      do_op("zz1", 16'h0000, 16'h0000, 1'b1, 1'b0);
      do_op("eq", 16'h5555, 16'h5555, 1'b0, 1'b0);
      do_op("ff", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
      do_op("busy_start", 16'h00C6, 16'h0006, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      chk("busy_start_idle", busy, 0);
      a = 16'h00C6; b = 16'h0000; borrow_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_diff", diff, 0);
      chk("abort_bo", borrow_out, 0);
      chk("abort_zero", zero, 0);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      chk("abort_quiet", extra, 0);
      do_op("after_rst", 16'h0008, 16'h0005, 1'b0, 1'b0);
      do_op("b2b_1", 16'h000A, 16'h0006, 1'b0, 1'b0);
      do_op("b2b_2", 16'h0003, 16'h0008, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++)
         do_op("rand", W'($urandom), W'($urandom), 1'($urandom), i[0]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 0 expected 1");
      $fatal(1);
   end
endmodule
